// File: rtl/twofish_pkg.sv
// Shared definitions for the Twofish encryption datapath and its sequencer.
package twofish_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      KEYGEN = 3'd1,
      KDRAIN = 3'd2,
      LOAD   = 3'd3,
      ROUND  = 3'd4,
      FINAL  = 3'd5,
      OUT    = 3'd6
   } state_t;

   localparam int unsigned DEFAULT_ROUNDS   = 16;
   localparam int unsigned NUM_WHITEN_PAIRS = 4;
   localparam int unsigned IN_WHITEN_IDX    = 0;
   localparam int unsigned OUT_WHITEN_IDX   = 2;
   localparam int unsigned ROUND_KEY_BASE   = 4;
   localparam int unsigned IDX_W            = 6;
   localparam int unsigned RND_W            = 5;

   // Subkey pair read by round r; round keys follow the four whitening pairs.
   function automatic logic [IDX_W-1:0] round_key_idx(input logic [IDX_W-1:0] r);
      return r + IDX_W'(ROUND_KEY_BASE);
   endfunction

endpackage

// File: rtl/twofish_enc_ctrl_if.sv
// Host handshake and datapath control bundle of the Twofish encryption sequencer.
interface twofish_enc_ctrl_if;
   import twofish_pkg::*;

   logic             in_valid;
   logic             in_new_key;
   logic             in_ready;
   logic [IDX_W-1:0] ks_idx;
   logic             ks_we;
   logic [IDX_W-1:0] ks_waddr;
   logic [IDX_W-1:0] rd_idx;
   logic             ld_in;
   logic             rnd_en;
   logic [RND_W-1:0] rnd_num;
   logic             ld_out;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             key_valid;

   modport master (
      output in_valid, in_new_key, out_ready,
      input  in_ready, ks_idx, ks_we, ks_waddr, rd_idx, ld_in, rnd_en,
             rnd_num, ld_out, out_valid, busy, key_valid
   );

   modport slave (
      input  in_valid, in_new_key, out_ready,
      output in_ready, ks_idx, ks_we, ks_waddr, rd_idx, ld_in, rnd_en,
             rnd_num, ld_out, out_valid, busy, key_valid
   );

endinterface

// File: rtl/twofish_ks_delay.sv
// Aligns subkey-store writes with the h-function output: HLAT-deep valid/address
// shift register, flushed by reset so no stale write survives an abort.
module twofish_ks_delay
   import twofish_pkg::*;
#(
   parameter int unsigned HLAT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_we,
   input  logic [IDX_W-1:0] in_addr,
   output logic             out_we,
   output logic [IDX_W-1:0] out_addr
);

   if (HLAT == 0) begin : g_pass
      assign out_we   = in_we;
      assign out_addr = in_addr;
   end else begin : g_pipe
      logic [HLAT-1:0]  we_r;
      logic [IDX_W-1:0] addr_r [HLAT];

      // Shift write strobe and address one stage per clock.
      always_ff @(posedge clk) begin
         if (reset) begin
            we_r <= {HLAT{1'b0}};
            for (int i = 0; i < int'(HLAT); i++) begin
               addr_r[i] <= {IDX_W{1'b0}};
            end
         end else begin
            we_r[0]   <= in_we;
            addr_r[0] <= in_addr;
            for (int i = 1; i < int'(HLAT); i++) begin
               we_r[i]   <= we_r[i-1];
               addr_r[i] <= addr_r[i-1];
            end
         end
      end

      assign out_we   = we_r[HLAT-1];
      assign out_addr = addr_r[HLAT-1];
   end

endmodule

// File: rtl/twofish_enc_ctrl.sv
// Twofish encryption sequencer: host handshake, key-expansion stepping and
// whitening/round timing. All control outputs are registered.
module twofish_enc_ctrl
   import twofish_pkg::*;
#(
   parameter int unsigned ROUNDS = DEFAULT_ROUNDS,
   parameter int unsigned HLAT   = 1
) (
   input logic               clk,
   input logic               reset,
   twofish_enc_ctrl_if.slave bus
);

   localparam int unsigned      NPAIRS     = NUM_WHITEN_PAIRS + ROUNDS;
   localparam logic [IDX_W-1:0] LAST_PAIR  = IDX_W'(NPAIRS - 1);
   localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(ROUNDS - 1);
   localparam logic [IDX_W-1:0] LAST_DRAIN = IDX_W'(HLAT - 1);

   state_t           state_r, state_s;
   logic [IDX_W-1:0] cnt_r, cnt_s;

   logic             in_ready_r, in_ready_s;
   logic             busy_r, busy_s;
   logic             key_valid_r, key_valid_s;
   logic             ks_gen_r, ks_gen_s;
   logic [IDX_W-1:0] ks_idx_r, ks_idx_s;
   logic [IDX_W-1:0] rd_idx_r, rd_idx_s;
   logic             ld_in_r, ld_in_s;
   logic             rnd_en_r, rnd_en_s;
   logic [RND_W-1:0] rnd_num_r, rnd_num_s;
   logic             ld_out_r, ld_out_s;
   logic             out_valid_r, out_valid_s;

   logic             ks_we_s;
   logic [IDX_W-1:0] ks_waddr_s;
   logic             last_write_s;

   twofish_ks_delay #(.HLAT(HLAT)) u_ks_delay (
      .clk      (clk),
      .reset    (reset),
      .in_we    (ks_gen_r),
      .in_addr  (ks_idx_r),
      .out_we   (ks_we_s),
      .out_addr (ks_waddr_s)
   );

   assign last_write_s = ks_we_s && (ks_waddr_s == LAST_PAIR);

   // Next-state and shared phase counter.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (bus.in_valid) begin
               cnt_s = {IDX_W{1'b0}};
               if (bus.in_new_key || !key_valid_r) begin
                  state_s = KEYGEN;
               end else begin
                  state_s = LOAD;
               end
            end else begin
               state_s = IDLE;
            end
         end
         KEYGEN: begin
            if (cnt_r == LAST_PAIR) begin
               cnt_s = {IDX_W{1'b0}};
               if (HLAT == 0) begin
                  state_s = LOAD;
               end else begin
                  state_s = KDRAIN;
               end
            end else begin
               cnt_s = cnt_r + 6'd1;
            end
         end
         KDRAIN: begin
            if (cnt_r == LAST_DRAIN) begin
               cnt_s   = {IDX_W{1'b0}};
               state_s = LOAD;
            end else begin
               cnt_s = cnt_r + 6'd1;
            end
         end
         LOAD: begin
            cnt_s   = {IDX_W{1'b0}};
            state_s = ROUND;
         end
         ROUND: begin
            if (cnt_r == LAST_ROUND) begin
               cnt_s   = {IDX_W{1'b0}};
               state_s = FINAL;
            end else begin
               cnt_s = cnt_r + 6'd1;
            end
         end
         FINAL: begin
            state_s = OUT;
         end
         OUT: begin
            if (bus.out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = OUT;
            end
         end
         default: begin
            cnt_s   = {IDX_W{1'b0}};
            state_s = IDLE;
         end
      endcase
   end

   // Output values decoded from the upcoming state so outputs can be registered.
   always_comb begin
      in_ready_s  = 1'b0;
      busy_s      = 1'b1;
      ks_gen_s    = 1'b0;
      ks_idx_s    = {IDX_W{1'b0}};
      rd_idx_s    = {IDX_W{1'b0}};
      ld_in_s     = 1'b0;
      rnd_en_s    = 1'b0;
      rnd_num_s   = {RND_W{1'b0}};
      ld_out_s    = 1'b0;
      out_valid_s = 1'b0;
      case (state_s)
         IDLE: begin
            in_ready_s = 1'b1;
            busy_s     = 1'b0;
         end
         KEYGEN: begin
            ks_gen_s = 1'b1;
            ks_idx_s = cnt_s;
         end
         KDRAIN: begin
            ks_gen_s = 1'b0;
         end
         LOAD: begin
            ld_in_s  = 1'b1;
            rd_idx_s = IDX_W'(IN_WHITEN_IDX);
         end
         ROUND: begin
            rnd_en_s  = 1'b1;
            rnd_num_s = cnt_s[RND_W-1:0];
            rd_idx_s  = round_key_idx(cnt_s);
         end
         FINAL: begin
            ld_out_s = 1'b1;
            rd_idx_s = IDX_W'(OUT_WHITEN_IDX);
         end
         OUT: begin
            out_valid_s = 1'b1;
         end
         default: begin
            busy_s = 1'b1;
         end
      endcase

      // A fresh expansion invalidates the store until its final pair lands.
      if ((state_r == IDLE) && (state_s == KEYGEN)) begin
         key_valid_s = 1'b0;
      end else if (last_write_s) begin
         key_valid_s = 1'b1;
      end else begin
         key_valid_s = key_valid_r;
      end
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         cnt_r       <= {IDX_W{1'b0}};
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
         key_valid_r <= 1'b0;
         ks_gen_r    <= 1'b0;
         ks_idx_r    <= {IDX_W{1'b0}};
         rd_idx_r    <= {IDX_W{1'b0}};
         ld_in_r     <= 1'b0;
         rnd_en_r    <= 1'b0;
         rnd_num_r   <= {RND_W{1'b0}};
         ld_out_r    <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         in_ready_r  <= in_ready_s;
         busy_r      <= busy_s;
         key_valid_r <= key_valid_s;
         ks_gen_r    <= ks_gen_s;
         ks_idx_r    <= ks_idx_s;
         rd_idx_r    <= rd_idx_s;
         ld_in_r     <= ld_in_s;
         rnd_en_r    <= rnd_en_s;
         rnd_num_r   <= rnd_num_s;
         ld_out_r    <= ld_out_s;
         out_valid_r <= out_valid_s;
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.busy      = busy_r;
   assign bus.key_valid = key_valid_r;
   assign bus.ks_idx    = ks_idx_r;
   assign bus.ks_we     = ks_we_s;
   assign bus.ks_waddr  = ks_waddr_s;
   assign bus.rd_idx    = rd_idx_r;
   assign bus.ld_in     = ld_in_r;
   assign bus.rnd_en    = rnd_en_r;
   assign bus.rnd_num   = rnd_num_r;
   assign bus.ld_out    = ld_out_r;
   assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_twofish_enc_ctrl.sv
// Randomized bench for twofish_enc_ctrl: three instances (HLAT 1, 0, 3) checked
// cycle by cycle against a block-schedule model derived from the timing rules.
module tb_twofish_enc_ctrl;

   localparam int ROUNDS = 16;
   localparam int NPAIRS = 4 + ROUNDS;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  in_valid_d;
   logic [2:0]  in_new_key_d;
   logic [2:0]  out_ready_d;
   logic [31:0] obs [3];

   int n_vec = 0;
   int n_err = 0;
   bit kv_model [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned HL_G = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
      twofish_enc_ctrl_if bus ();
      assign bus.in_valid   = in_valid_d[g];
      assign bus.in_new_key = in_new_key_d[g];
      assign bus.out_ready  = out_ready_d[g];
      assign obs[g] = {1'b0, bus.in_ready, bus.busy, bus.key_valid, bus.ks_we,
                       bus.ld_in, bus.rnd_en, bus.ld_out, bus.out_valid,
                       bus.ks_idx, bus.ks_waddr, bus.rd_idx, bus.rnd_num};
      twofish_enc_ctrl #(.ROUNDS(ROUNDS), .HLAT(HL_G)) dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus)
      );
   end

   function automatic int hlat_of(int i);
      case (i)
         0:       return 1;
         1:       return 0;
         default: return 3;
      endcase
   endfunction

   function automatic logic [31:0] pack_exp(bit ir, bit bz, bit kv, bit we, bit li, bit re,
                                            bit lo, bit ov, int ki, int wa, int ri, int rn);
      return {1'b0, ir, bz, kv, we, li, re, lo, ov, 6'(ki), 6'(wa), 6'(ri), 5'(rn)};
   endfunction

   // Expected outputs t edges after the accept edge (t=1 is the first busy cycle).
   function automatic logic [31:0] expect_at(int i, bit kg, int t);
      int  hl = hlat_of(i);
      int  k  = kg ? NPAIRS + hl : 0;
      int  r  = t - k - 2;
      bit  we = kg && (t - hl >= 1) && (t - hl <= NPAIRS);
      bit  re = (r >= 0) && (r < ROUNDS);
      bit  lo = (t == k + ROUNDS + 2);
      bit  kv = kg ? (t > NPAIRS + hl) : kv_model[i];
      int  ki = (kg && t <= NPAIRS) ? t - 1 : 0;
      int  ri = re ? r + 4 : (lo ? 2 : 0);
      return pack_exp(1'b0, 1'b1, kv, we, t == k + 1, re, lo, t >= k + ROUNDS + 3,
                      ki, we ? t - 1 - hl : 0, ri, re ? r : 0);
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(int i, int n);
      for (int c = 0; c < n; c++) begin
         in_valid_d[i]   = 1'b0;
         in_new_key_d[i] = 1'($urandom);
         out_ready_d[i]  = 1'($urandom);
         step();
         chk($sformatf("idle_i%0d", i), obs[i],
             pack_exp(1'b1, 1'b0, kv_model[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0));
      end
   endtask

   // One block from accept to the return to IDLE; abort_t>0 resets at that cycle.
   task automatic run_block(int i, bit nk, int stall, int abort_t);
      bit kg   = nk || !kv_model[i];
      int tout = (kg ? NPAIRS + hlat_of(i) : 0) + ROUNDS + 3;
      int lat  = kg ? NPAIRS + hlat_of(i) + ROUNDS + 2 : ROUNDS + 2;
      int t    = 0;
      bit done = 1'b0;
      bit seen = 1'b0;
      in_valid_d[i]   = 1'b1;
      in_new_key_d[i] = nk;
      out_ready_d[i]  = 1'($urandom);
      while (!done && t < 300) begin
         step();
         t++;
         chk($sformatf("blk_i%0d_t%0d", i, t), obs[i], expect_at(i, kg, t));
         if (obs[i][23] && !seen) begin
            seen = 1'b1;
            chk($sformatf("latency_i%0d", i), 32'(t - 1), 32'(lat));
         end
         if (abort_t != 0 && t == abort_t) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            in_valid_d[i] = 1'b0;
            for (int j = 0; j < 3; j++) kv_model[j] = 1'b0;
            chk($sformatf("abort_i%0d", i), obs[i],
                pack_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0));
            idle_cycles(i, 5);
            return;
         end
         in_valid_d[i]   = 1'($urandom);
         in_new_key_d[i] = 1'($urandom);
         if (t >= tout) begin
            out_ready_d[i] = (t >= tout + stall);
            done = out_ready_d[i];
         end else begin
            out_ready_d[i] = 1'($urandom);
         end
      end
      chk($sformatf("done_i%0d", i), 32'(done), 32'd1);
      step();
      in_valid_d[i] = 1'b0;
      if (kg) kv_model[i] = 1'b1;
      chk($sformatf("end_i%0d", i), obs[i],
          pack_exp(1'b1, 1'b0, kv_model[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0));
   endtask

   initial begin
      reset        = 1'b1;
      in_valid_d   = 3'b000;
      in_new_key_d = 3'b000;
      out_ready_d  = 3'b000;
      for (int j = 0; j < 3; j++) kv_model[j] = 1'b0;
      step();
      step();
      for (int j = 0; j < 3; j++) begin
         chk($sformatf("reset_i%0d", j), obs[j],
             pack_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0));
      end
      reset = 1'b0;
      idle_cycles(0, 2);

      // Directed: forced expansion, cached key, new key, long stall, abort.
      run_block(0, 1'b0, 0, 0);
      run_block(0, 1'b0, 0, 0);
      run_block(0, 1'b1, 0, 0);
      run_block(0, 1'b0, 10, 0);
      run_block(0, 1'b1, 0, 8);
      run_block(0, 1'b0, 0, 0);

      // Randomized block mix.
      for (int n = 0; n < 12; n++) begin
         run_block(0, ($urandom_range(0, 3) == 0), $urandom_range(0, 6), 0);
         idle_cycles(0, $urandom_range(0, 3));
      end

      // Subkey latency sweep.
      run_block(1, 1'b0, 0, 0);
      run_block(1, 1'b0, 2, 0);
      run_block(1, 1'b1, 0, 0);
      run_block(2, 1'b1, 0, 0);
      run_block(2, 1'b0, 3, 0);
      run_block(2, 1'b0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/twofish_enc_ctrl.md
Name: twofish_enc_ctrl

Overview:
Sequencer for the pipelined Twofish encryption datapath. It owns the host valid/ready handshake and drives the datapath control strobes. It steps the subkey generator (h-function index) over all 20 subkey pairs and fills the subkey store, then times input whitening, the 16 round-function iterations and output whitening. It caches key validity so that blocks under an unchanged key skip key expansion.

Parameters:
ROUNDS, 16, number of F-function rounds; must be 1..32.
HLAT, 1, latency in cycles from ks_idx issue to valid subkey pair at store input; must be 0..3.
NPAIRS, 4+ROUNDS, localparam: subkey pairs generated (pairs 0-1 input whiten, 2-3 output whiten, 4.. rounds).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  host offers block (plaintext/key held stable by host while in_valid)
in_new_key  in  1  qualifies in_valid: key differs from last expanded key
in_ready  out  1  controller can accept a block
ks_idx  out  6  pair index i driven to h-function generator
ks_we  out  1  write generated pair into subkey store
ks_waddr  out  6  store write address (ks_idx delayed HLAT cycles)
rd_idx  out  6  subkey store read pair index (whitening reads rd_idx and rd_idx+1)
ld_in  out  1  load input-whitened block into round registers
rnd_en  out  1  advance round registers one round
rnd_num  out  5  current round number 0..ROUNDS-1
ld_out  out  1  capture output-whitened block into output register
out_valid  out  1  ciphertext register valid
out_ready  in  1  host consumes ciphertext
busy  out  1  state != IDLE
key_valid  out  1  subkey store holds a completely expanded key

Behaviour:
- Reset state: state=IDLE, key_valid=0, in_ready=1, busy=0, and all strobes (ks_we, ld_in, rnd_en, ld_out, out_valid)=0. ks_idx, ks_waddr, rd_idx and rnd_num reset to 0. Reset mid-operation aborts immediately, clears key_valid and drops out_valid. The HLAT delay line is flushed, so no ks_we appears after reset.
- Handshake: accept when in_valid & in_ready at a clock edge. in_ready = (state==IDLE).
- Key decision at accept: go to KEYGEN if in_new_key=1 or key_valid=0, else go to LOAD.
- FSM states: IDLE, KEYGEN, KDRAIN, LOAD, ROUND, FINAL, OUT.
- KEYGEN: NPAIRS cycles. ks_idx counts 0..NPAIRS-1, one per cycle. key_valid is cleared on entry. Exits to KDRAIN, or to LOAD directly when HLAT=0.
- KDRAIN: HLAT cycles for the last pairs to emerge.
- Key writes: ks_we/ks_waddr are ks_idx delayed by exactly HLAT cycles through a shift register. Exactly NPAIRS writes occur, at addresses 0..NPAIRS-1 ascending. key_valid is set in the cycle after the last write.
- LOAD: 1 cycle, ld_in=1, rd_idx=0.
- ROUND: ROUNDS cycles, rnd_en=1, rnd_num=r, rd_idx=r+4 for r=0..ROUNDS-1.
- FINAL: 1 cycle, ld_out=1, rd_idx=2.
- OUT: out_valid=1, held until out_ready sampled high. Then return to IDLE; out_valid drops the same edge.
- Latency from accept edge to first out_valid cycle:
  - with key expansion: NPAIRS+HLAT+ROUNDS+2 (39 at defaults);
  - without key expansion: ROUNDS+2 (18).
- Throughput: no overlap; a new block is only accepted in IDLE (one idle cycle minimum between blocks).
- Strobe exclusivity: ld_in, rnd_en and ld_out are one-hot-or-zero every cycle. ks_we is never high outside KEYGEN/KDRAIN.
- Idle outputs: when not in ROUND, rnd_num holds 0. Outside LOAD/ROUND/FINAL, rd_idx holds 0.
- in_new_key is ignored unless sampled with an accepting handshake.
- out_ready asserted outside OUT has no effect.
- Counter widths: the shared 6-bit counter never wraps, because max NPAIRS=36 < 64.

Decomposition:
- Shared package twofish_pkg:
  - state enum type;
  - constants NUM_WHITEN_PAIRS=4, IN_WHITEN_IDX=0, OUT_WHITEN_IDX=2, ROUND_KEY_BASE=4;
  - default ROUNDS, shared with the datapath modules.
- One sub-module, twofish_ks_delay: HLAT-deep valid/address shift register producing ks_we/ks_waddr, with synchronous flush on reset.
- FSM and counters stay in the top.

Test Plan:
- First block after reset, in_new_key=0 (key_valid=0) -> KEYGEN forced. ks_idx runs 0..19; 20 ks_we pulses at ks_waddr 0..19, one cycle late. key_valid rises. ld_in at cycle 22, rnd_en cycles 23-38 with rd_idx 4..19, ld_out at cycle 39, out_valid at cycle 40 (accept edge = cycle 1).
- Second block with in_new_key=0, out_ready tied high -> no ks_we. ld_in the cycle after accept, out_valid exactly 18 cycles after accept, IDLE again next cycle.
- Second block with in_new_key=1 -> full 39-cycle latency; key_valid low throughout KEYGEN/KDRAIN.
- out_ready held low 10 cycles in OUT -> out_valid stays high, in_ready stays 0, and a presented in_valid is not accepted until after the out_ready handshake.
- Reset asserted at ks_idx=7 -> next cycle IDLE, key_valid=0, no ks_we after reset. The next block is forced through KEYGEN.
- Parameter sweep HLAT=0 and HLAT=3 with ROUNDS=16 -> latency 38 and 41. ks_waddr equals ks_idx delayed by HLAT. Strobe one-hot assertion never fires.
